// File: rtl/svm_pkg.sv
// Shared defaults and helpers for the linear-SVM scoring sequencer.
package svm_pkg;

  localparam int SW_W_DEF    = 11;
  localparam int N_FEAT_DEF  = 36;
  localparam int NUM_SW_DEF  = 1200;
  localparam int RAM_LAT_DEF = 1;
  localparam int PE_LAT_DEF  = 2;

  // Address width for n words, never narrower than one bit
  function automatic int clog2_min1(input int n);
    int r;
    if (n <= 2) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/svm_delay_line.sv
// Fixed-depth shift register with async reset and synchronous flush; DEPTH=0 is a wire.
module svm_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_s;
    assign unused_s = clk ^ rst ^ clear;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift stages each cycle; clear flushes every stage at once
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
      end else if (clear) begin
        for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
      end else begin
        stage_r[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/svm_seq_ctrl.sv
// Linear-SVM scoring sequencer: counts feature beats per slide window, drives the
// weight-RAM address and PE init/accumulate, and flags each completed window result.
module svm_seq_ctrl
  import svm_pkg::*;
#(
  parameter  int SW_W    = SW_W_DEF,
  parameter  int N_FEAT  = N_FEAT_DEF,
  parameter  int NUM_SW  = NUM_SW_DEF,
  parameter  int RAM_LAT = RAM_LAT_DEF,
  parameter  int PE_LAT  = PE_LAT_DEF,
  localparam int ADDR_W  = clog2_min1(N_FEAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] addr_b,
  output logic              init,
  output logic              accumulate,
  output logic [SW_W-1:0]   sw_id,
  output logic              o_valid,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] BEAT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] BEAT_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BEAT_LAST = ADDR_W'(N_FEAT - 1);
  localparam logic [SW_W-1:0]   WIN_ZERO  = {SW_W{1'b0}};
  localparam logic [SW_W-1:0]   WIN_ONE   = SW_W'(1);
  localparam logic [SW_W-1:0]   WIN_LAST  = SW_W'(NUM_SW - 1);

  logic [ADDR_W-1:0] beat_r;
  logic [SW_W-1:0]   win_r;
  logic              accept_s;
  logic              beat_last_s;
  logic              win_last_s;
  logic              win_done_s;
  logic              init_s;
  logic              acc_s;
  logic [1:0]        cmd_q_s;
  logic [SW_W+1:0]   res_q_s;
  logic              res_valid_s;
  logic              res_last_s;
  logic [SW_W-1:0]   res_sw_s;
  logic [SW_W-1:0]   sw_hold_r;
  logic              last_hold_r;

  // Beat acceptance and end-of-window / end-of-frame decode
  always_comb begin
    accept_s    = i_valid & ~i_clear;
    beat_last_s = (beat_r == BEAT_LAST);
    win_last_s  = (win_r == WIN_LAST);
    win_done_s  = accept_s & beat_last_s;
    init_s      = accept_s & (beat_r == BEAT_ZERO);
    acc_s       = accept_s & (beat_r != BEAT_ZERO);
  end

  // Beat and window counters; i_clear restarts at beat 0 of window 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_r <= BEAT_ZERO;
      win_r  <= WIN_ZERO;
    end else if (i_clear) begin
      beat_r <= BEAT_ZERO;
      win_r  <= WIN_ZERO;
    end else if (accept_s) begin
      if (beat_last_s) begin
        beat_r <= BEAT_ZERO;
        win_r  <= win_last_s ? WIN_ZERO : win_r + WIN_ONE;
      end else begin
        beat_r <= beat_r + BEAT_ONE;
        win_r  <= win_r;
      end
    end else begin
      beat_r <= beat_r;
      win_r  <= win_r;
    end
  end

  assign addr_b = beat_r;

  svm_delay_line #(.WIDTH(2), .DEPTH(RAM_LAT)) u_cmd_dly (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .d     ({init_s, acc_s}),
    .q     (cmd_q_s)
  );

  assign init       = cmd_q_s[1];
  assign accumulate = cmd_q_s[0];

  // Window tag travels with its done flag so overlapping windows stay distinct
  svm_delay_line #(.WIDTH(SW_W + 2), .DEPTH(RAM_LAT + PE_LAT)) u_res_dly (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .d     ({win_done_s, win_last_s, win_r}),
    .q     (res_q_s)
  );

  assign res_valid_s = res_q_s[SW_W+1];
  assign res_last_s  = res_q_s[SW_W];
  assign res_sw_s    = res_q_s[SW_W-1:0];

  // Remember the most recent result tag so sw_id/o_last hold between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_hold_r   <= WIN_ZERO;
      last_hold_r <= 1'b0;
    end else if (res_valid_s) begin
      sw_hold_r   <= res_sw_s;
      last_hold_r <= res_last_s;
    end else begin
      sw_hold_r   <= sw_hold_r;
      last_hold_r <= last_hold_r;
    end
  end

  // Result outputs; the live tag is passed straight through when PE_LAT+RAM_LAT is zero
  always_comb begin
    o_valid = res_valid_s;
    if (res_valid_s) begin
      sw_id  = res_sw_s;
      o_last = res_last_s;
    end else begin
      sw_id  = sw_hold_r;
      o_last = last_hold_r;
    end
  end

endmodule

// File: tb/tb_svm_seq_ctrl.sv
// Directed self-checking bench for svm_seq_ctrl: default config plus a short-frame
// variant and an N_FEAT=1 zero-latency variant sharing the same stimulus.
module tb_svm_seq_ctrl;

  logic clk;
  logic rst;
  logic i_valid;
  logic i_clear;

  logic [5:0]  d_addr;
  logic        d_init, d_acc, d_ov, d_last;
  logic [10:0] d_sw;

  logic [1:0]  s4_addr;
  logic        s4_init, s4_acc, s4_ov, s4_last;
  logic [10:0] s4_sw;

  logic [0:0]  n1_addr;
  logic        n1_init, n1_acc, n1_ov, n1_last;
  logic [10:0] n1_sw;

  int total = 0;
  int bad   = 0;

  svm_seq_ctrl u_def (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_clear(i_clear),
    .addr_b(d_addr), .init(d_init), .accumulate(d_acc),
    .sw_id(d_sw), .o_valid(d_ov), .o_last(d_last)
  );

  svm_seq_ctrl #(.N_FEAT(3), .NUM_SW(4)) u_s4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_clear(i_clear),
    .addr_b(s4_addr), .init(s4_init), .accumulate(s4_acc),
    .sw_id(s4_sw), .o_valid(s4_ov), .o_last(s4_last)
  );

  svm_seq_ctrl #(.N_FEAT(1), .NUM_SW(3), .RAM_LAT(0), .PE_LAT(0)) u_n1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_clear(i_clear),
    .addr_b(n1_addr), .init(n1_init), .accumulate(n1_acc),
    .sw_id(n1_sw), .o_valid(n1_ov), .o_last(n1_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the sampling point.
  task automatic step(input logic v, input logic c);
    @(posedge clk);
    #1;
    i_valid = v;
    i_clear = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_clear = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("rst_addr", d_addr, 0);
    chk("rst_init", d_init, 0);
    chk("rst_acc",  d_acc,  0);
    chk("rst_ov",   d_ov,   0);
    chk("rst_sw",   d_sw,   0);
    chk("rst_last", d_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int exp_t[$];
  int exp_w[$];
  int accepted;
  int pulses;
  int k;
  logic v;

  initial begin
    // Phase 1: defaults, i_valid high for 72 cycles
    do_reset();
    for (int t = 0; t < 77; t++) begin
      step(t < 72, 1'b0);
      chk("p1_addr", d_addr, (t < 72) ? t % 36 : 0);
      chk("p1_init", d_init, (t >= 1 && t <= 72 && (t - 1) % 36 == 0) ? 1 : 0);
      chk("p1_acc",  d_acc,  (t >= 2 && t <= 72 && (t - 1) % 36 != 0) ? 1 : 0);
      chk("p1_ov",   d_ov,   (t == 38 || t == 74) ? 1 : 0);
      if (t == 38 || t == 74) begin
        chk("p1_sw",   d_sw,   (t == 38) ? 0 : 1);
        chk("p1_last", d_last, 0);
      end
    end
    chk("p1_sw_hold", d_sw, 1);

    // Phase 2: random 25% duty over 3 windows, pulse 3 cycles after beat 35
    do_reset();
    accepted = 0;
    pulses   = 0;
    for (int t = 0; t < 3000; t++) begin
      v = (accepted < 108) && ($urandom_range(0, 3) == 0);
      step(v, 1'b0);
      chk("p2_addr", d_addr, accepted % 36);
      if (exp_t.size() > 0 && exp_t[0] == t) begin
        chk("p2_ov_hit", d_ov, 1);
        chk("p2_sw", d_sw, exp_w[0]);
        void'(exp_t.pop_front());
        void'(exp_w.pop_front());
      end else begin
        chk("p2_ov_idle", d_ov, 0);
      end
      if (d_ov) pulses++;
      if (v) begin
        if (accepted % 36 == 35) begin
          exp_t.push_back(t + 3);
          exp_w.push_back(accepted / 36);
        end
        accepted++;
      end
      if (accepted == 108 && exp_t.size() == 0) break;
    end
    chk("p2_drained", exp_t.size(), 0);
    chk("p2_count", pulses, 3);

    // Phase 3: NUM_SW=4, N_FEAT=3 -> five windows, o_last only on sw_id 3
    do_reset();
    k = 0;
    for (int t = 0; t < 22; t++) begin
      step(t < 15, 1'b0);
      if (s4_ov) begin
        chk("p3_time", t, 3 * k + 5);
        chk("p3_sw", s4_sw, k % 4);
        chk("p3_last", s4_last, (k % 4 == 3) ? 1 : 0);
        k++;
      end
    end
    chk("p3_count", k, 5);

    // Phase 4: i_clear at beat 20 of window 2
    do_reset();
    for (int t = 0; t <= 92; t++) begin
      step(1'b1, t == 92);
      chk("p4_ov", d_ov, (t == 38 || t == 74) ? 1 : 0);
      if (t == 74) chk("p4_sw1", d_sw, 1);
    end
    chk("p4_addr_at_clear", d_addr, 20);
    for (int t = 93; t < 100; t++) begin
      step(1'b0, 1'b0);
      chk("p4_addr_cleared", d_addr, 0);
      chk("p4_init_drain", d_init, 0);
      chk("p4_acc_drain", d_acc, 0);
      chk("p4_ov_drain", d_ov, 0);
    end
    for (int t = 100; t < 141; t++) begin
      step(t < 136, 1'b0);
      chk("p4_ov_new", d_ov, (t == 138) ? 1 : 0);
      if (t == 138) begin
        chk("p4_sw_new", d_sw, 0);
        chk("p4_last_new", d_last, 0);
      end
    end

    // Phase 5: async reset mid-cycle at window 1 beat 10
    do_reset();
    for (int t = 0; t < 47; t++) step(1'b1, 1'b0);
    chk("p5_addr_pre", d_addr, 10);
    chk("p5_acc_pre", d_acc, 1);
    rst = 1'b0;
    #1;
    chk("p5_addr_rst", d_addr, 0);
    chk("p5_acc_rst", d_acc, 0);
    chk("p5_init_rst", d_init, 0);
    chk("p5_ov_rst", d_ov, 0);
    chk("p5_sw_rst", d_sw, 0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 1'b0);
      chk("p5_ov_post", d_ov, 0);
      chk("p5_acc_post", d_acc, 0);
    end

    // Phase 6: N_FEAT=1 zero-latency instance
    do_reset();
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 1'b0);
      chk("p6_init", n1_init, 1);
      chk("p6_acc", n1_acc, 0);
      chk("p6_ov", n1_ov, 1);
      chk("p6_sw", n1_sw, t % 3);
      chk("p6_last", n1_last, (t % 3 == 2) ? 1 : 0);
    end
    step(1'b0, 1'b0);
    chk("p6_init_idle", n1_init, 0);
    chk("p6_ov_idle", n1_ov, 0);
    chk("p6_sw_hold", n1_sw, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
